// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family: FSM state encoding and default widths.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_PRESC_W = 4;

endpackage

// File: rtl/counter_prescaler.sv
// Clock prescaler: raises step on the cycle its count matches presc, then restarts from 0.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESC_W = DEFAULT_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               step
);

  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] cnt;

  assign step = en && (cnt == presc);

  // clr outranks counting so a load or restart always begins a fresh prescale period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= step ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/up_counter_mod.sv
// Programmable up counter with prescaler, synchronous load, and continuous or one-shot modes.
// Handshake: start/stop/load are level-sampled each rising clk edge; no ready/ack path exists.
module up_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PRESC_W = DEFAULT_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   mod_val,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] count_next;
  logic             tick_next;
  logic             os_latch, os_next;
  logic             presc_clr;
  logic             step;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] inc;

  // mod_val of 0 wraps to all ones, giving a full 2^WIDTH period
  assign top       = mod_val - ONE_W;
  assign inc       = count + ONE_W;
  assign state_dbg = state;

  counter_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr   (presc_clr),
    .en    ((state == RUN) && en),
    .presc (presc),
    .step  (step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      tick     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      os_latch <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      tick     <= tick_next;
      busy     <= (state_next == RUN);
      done     <= (state_next == DONE);
      os_latch <= os_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    tick_next  = 1'b0;
    os_next    = os_latch;
    presc_clr  = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (!stop && start) begin
          state_next = RUN;
          count_next = '0;
          presc_clr  = 1'b1;
          os_next    = oneshot;
        end else if (stop) begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (step) begin
          // >= also catches a lowered mod_val or an out-of-range load
          if (os_latch) begin
            if (inc == top || count >= top) begin
              count_next = top;
              tick_next  = 1'b1;
              state_next = DONE;
            end else begin
              count_next = inc;
            end
          end else if (count >= top) begin
            count_next = '0;
            tick_next  = 1'b1;
          end else begin
            count_next = inc;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // load overrides any step or restart value, but the state move still stands
    if (load) begin
      count_next = load_val;
      tick_next  = 1'b0;
      presc_clr  = 1'b1;
    end
  end

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed bench for up_counter_mod: hand-computed expectations checked with immediate assertions.
module tb_up_counter_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, oneshot, en, load;
  logic [3:0] load_val, mod_val, presc;
  logic [3:0] count;
  logic       tick, busy, done;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt;

  up_counter_mod #(.WIDTH(4), .PRESC_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .mod_val   (mod_val),
    .presc     (presc),
    .count     (count),
    .tick      (tick),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0; en = 1'b1; load = 1'b0;
    load_val = 4'd0; mod_val = 4'd0; presc = 4'd0;

    // reset held across edges
    #3;
    check("rst_count", 32'(count), 32'd0);
    cyc(); cyc();
    check("rst_count_hold", 32'(count), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b1;
    cyc();
    check("idle_after_rst", 32'(busy), 32'd0);

    // continuous, mod 16, presc 0
    start = 1'b1; cyc(); start = 1'b0;
    check("p1_start_count", 32'(count), 32'd0);
    check("p1_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 19; i++) begin
      cyc();
      check("p1_count", 32'(count), 32'(i % 16));
      check("p1_tick", 32'(tick), 32'(i == 16));
    end
    check("p1_busy_end", 32'(busy), 32'd1);
    stop = 1'b1; cyc(); stop = 1'b0;
    check("p1_stop_hold", 32'(count), 32'd3);
    check("p1_stop_busy", 32'(busy), 32'd0);
    check("p1_stop_state", 32'(state_dbg), 32'd0);

    // continuous, mod 10, presc 2: one tick in 30 clks
    mod_val = 4'd10; presc = 4'd2;
    start = 1'b1; cyc(); start = 1'b0;
    check("p2_start_count", 32'(count), 32'd0);
    tick_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      tick_cnt += int'(tick);
      check("p2_count", 32'(count), 32'((k / 3) % 10));
    end
    check("p2_tick_total", 32'(tick_cnt), 32'd1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // one-shot, mod 5
    oneshot = 1'b1; mod_val = 4'd5; presc = 4'd0;
    start = 1'b1; cyc(); start = 1'b0;
    check("p3_start_count", 32'(count), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("p3_count", 32'(count), 32'(k));
      check("p3_tick", 32'(tick), 32'(k == 4));
      check("p3_done", 32'(done), 32'(k == 4));
      check("p3_busy", 32'(busy), 32'(k != 4));
    end
    cyc(); cyc();
    check("p3_hold_count", 32'(count), 32'd4);
    check("p3_hold_tick", 32'(tick), 32'd0);
    check("p3_hold_done", 32'(done), 32'd1);
    start = 1'b1; cyc(); start = 1'b0;
    check("p3_restart_count", 32'(count), 32'd0);
    check("p3_restart_busy", 32'(busy), 32'd1);
    check("p3_restart_done", 32'(done), 32'd0);
    stop = 1'b1; cyc(); stop = 1'b0;

    // mid-run out-of-range load
    oneshot = 1'b0; mod_val = 4'd10; presc = 4'd0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    check("p4_pre_load", 32'(count), 32'd3);
    load = 1'b1; load_val = 4'd12; cyc(); load = 1'b0;
    check("p4_load_count", 32'(count), 32'd12);
    check("p4_load_tick", 32'(tick), 32'd0);
    cyc();
    check("p4_wrap_count", 32'(count), 32'd0);
    check("p4_wrap_tick", 32'(tick), 32'd1);
    cyc();
    check("p4_after_count", 32'(count), 32'd1);
    check("p4_after_tick", 32'(tick), 32'd0);
    stop = 1'b1; cyc(); stop = 1'b0;
    check("p4_stop_count", 32'(count), 32'd1);

    // start and stop together from IDLE
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    check("ss_busy", 32'(busy), 32'd0);
    check("ss_state", 32'(state_dbg), 32'd0);
    check("ss_count", 32'(count), 32'd1);

    // en freeze, presc 1
    presc = 4'd1;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    check("p5_count2", 32'(count), 32'd1);
    cyc();
    en = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      check("p5_frozen_count", 32'(count), 32'd1);
      check("p5_frozen_tick", 32'(tick), 32'd0);
    end
    en = 1'b1;
    cyc();
    check("p5_resume_count", 32'(count), 32'd2);
    cyc();
    check("p5_resume_hold", 32'(count), 32'd2);
    cyc();
    check("p5_resume_next", 32'(count), 32'd3);
    stop = 1'b1; cyc(); stop = 1'b0;

    // asynchronous reset mid-count
    mod_val = 4'd0; presc = 4'd0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 0; k < 7; k++) cyc();
    check("p6_pre_rst", 32'(count), 32'd7);
    #2 rst = 1'b0;
    #1;
    check("p6_rst_count", 32'(count), 32'd0);
    check("p6_rst_tick", 32'(tick), 32'd0);
    check("p6_rst_busy", 32'(busy), 32'd0);
    check("p6_rst_done", 32'(done), 32'd0);
    #2 rst = 1'b1;
    cyc(); cyc(); cyc();
    check("p6_idle_count", 32'(count), 32'd0);
    check("p6_idle_busy", 32'(busy), 32'd0);
    start = 1'b1; cyc(); start = 1'b0;
    check("p6_start_busy", 32'(busy), 32'd1);
    cyc();
    check("p6_start_count", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/up_counter_mod.md
Name: up_counter_mod

Overview:
- Programmable up counter; the counting-up counterpart of the team's down_counter.
- Counts from 0 up to a runtime modulus minus one, with a clock prescaler, synchronous load, and continuous or one-shot modes.
- Emits a single-cycle terminal-count tick.
- Sits beside down_counter as a shared timing/event-count primitive for timers and baud/strobe generation.

Parameters:
- WIDTH, 4, counter width in bits.
- PRESC_W, 4, prescaler width; step rate is clk/(presc+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  begin counting from 0; samples oneshot.
- stop  input  1  halt counting; count value is held.
- oneshot  input  1  1 = stop at top value, 0 = wrap continuously.
- en  input  1  step qualifier; prescaler and counter freeze while 0.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value for load.
- mod_val  input  WIDTH  modulus; top = mod_val-1; 0 means 2^WIDTH (top = all ones).
- presc  input  PRESC_W  prescale divisor minus one.
- count  output  WIDTH  current count.
- tick  output  1  one-cycle pulse on the step that reaches or passes top.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (one-shot finished).

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, prescaler=0, tick=0, busy=0, done=0, oneshot latch=0. Outputs are registered and stay at these values until the first clk edge after rst rises.
- States:
  - IDLE: start -> RUN (count=0, prescaler=0, latch oneshot).
  - RUN: stop -> IDLE; one-shot terminal step -> DONE.
  - DONE: start -> RUN (same init as from IDLE); stop -> IDLE.
- Same-cycle start and stop: stop wins.
- start while already in RUN is ignored.
- Step condition: state==RUN && en && prescaler==presc.
  - On a step the prescaler returns to 0.
  - Otherwise, in RUN with en=1, the prescaler increments.
  - presc=0 gives one step per clk.
- Step action, continuous mode:
  - count >= top: count <= 0, tick=1.
  - else: count <= count+1.
  - The >= compare covers mod_val lowered mid-run and out-of-range loads.
- Step action, one-shot mode:
  - count+1 == top or count >= top: count <= top, tick=1, state <= DONE.
  - else: count <= count+1.
- Load (any state): count <= load_val, prescaler <= 0, no tick. Load beats a coincident step and a coincident start's zeroing. State transitions in the same cycle still occur.
- tick is registered, asserted the cycle after the stepping edge is visible, with the same timing as the count update. It is never high two consecutive cycles unless top=0 (mod_val=1, presc=0), where it is high every step.
- mod_val=1: top=0; count stays 0 and ticks every step.
- mod_val=0: wraps at 2^WIDTH-1 -> 0. Arithmetic is WIDTH-bit unsigned; no internal overflow beyond that.
- busy = (state==RUN); done = (state==DONE); both registered.
- en=0 in RUN: everything frozen, no tick. stop/load still act.
- rst asserted mid-count: immediate return to reset values, independent of clk.

Decomposition:
- Shared package (counter_pkg): state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2; default WIDTH/PRESC_W.
- One natural sub-module: prescaler (counter_prescaler), with ports clk, rst, clr, en, presc, step. The main FSM and counter live in up_counter_mod.

Test Plan:
- Reset, then start with mod_val=0, presc=0, oneshot=0, en=1 for 20 cycles -> count 0,1,..,15,0,1,2,3; tick high exactly on the 15->0 step; busy=1.
- mod_val=10, presc=2, continuous -> count advances every 3rd clk, 9->0 with tick; 30 clks after start yield exactly one tick.
- oneshot=1, mod_val=5, presc=0 -> count 0..4, tick at 4, done=1, busy=0, count holds 4; second start -> count=0, RUN again.
- Mid-run load_val=12 with mod_val=10 -> next step wraps to 0 with tick. Same-cycle start+stop from IDLE -> stays IDLE, count unchanged.
- en toggled 0 for 7 cycles mid-run -> count and prescaler frozen, no tick; resumes from same value.
- rst pulsed low asynchronously between clk edges at count=7 -> count=0, tick=0, busy=0, done=0 immediately; stays IDLE after release until start.
